adpcm_quantl_search: RTL
========================

# adpcm_quantl_search

Sequential quantiser-search stage for the ADPCM encoder datapath. It takes a signed difference sample `el` and a scale factor `detl`. It walks a fixed 16-entry threshold table, scaling each entry by `detl` through a 15x11 unsigned multiplier, and returns the first table index whose scaled threshold is not below `|el|`, packed with the sign of `el` as a 5-bit code. It sits directly downstream of the encoder's 15x11 multiplier and consumes the 27-bit product every iteration. It uses the design's ap_ctrl start/done handshake.

## Interface
- `SHIFT`, default 11: right shift applied to the 27-bit product to form the threshold.
- `NENT`, default 16: table depth; fixed by the package, not overridable.
- `ap_clk  in  1`: clock. One clock domain. All state changes on the rising edge.
- `ap_rst  in  1`: reset. Synchronous, active-high.
- `ap_start  in  1`: level request; sampled only in S_IDLE.
- `ap_done  out  1`: one-cycle pulse when `ilr` is updated.
- `ap_idle  out  1`: high in S_IDLE.
- `ap_ready  out  1`: one-cycle pulse, coincident with `ap_done`.
- `el  in  16`: signed difference sample; captured on start.
- `detl  in  15`: unsigned scale factor; captured on start.
- `ilr  out  5`: result code {sign, index[3:0]}; held until the next completion.

## Operation
- States: S_IDLE, S_MUL, S_CMP, S_DONE.
- **S_IDLE**, when `ap_start` is high:
  - capture `detl_r`, `sign_r = el[15]`, `wd_r = |el|` saturated to 15 bits (-32768 gives 32767);
  - set `k = 0`; go to S_MUL.
- **S_MUL**: `prod_r <= T[k] * detl_r`, a 27-bit unsigned product; go to S_CMP.
- **S_CMP**: compute `thr = prod_r >> SHIFT`, 16 bits.
  - If `wd_r <= thr` or `k == 15`: `ilr <= {sign_r, k}`; go to S_DONE.
  - Otherwise: `k <= k + 1`; go to S_MUL.
- **S_DONE**: assert `ap_done` and `ap_ready`; go to S_IDLE.
- Index 15 is a saturating catch-all: reaching it always terminates the search.
- `ap_start` outside S_IDLE is ignored and never queued.
- `ap_start` held high through S_DONE starts a new search on the next S_IDLE cycle (back-to-back).
- Table: `T[k] = 128*(k+1)` for k = 0..14, and `T[15] = 2047`. All entries are 11-bit unsigned.
- All arithmetic is unsigned except the sign extraction from `el`. No truncation of the product before the shift.

## Timing
- Reset values: S_IDLE; `ap_idle = 1`; `ap_done = 0`; `ap_ready = 0`; `ilr = 0`; `k = 0`; `prod_r = 0`.
- Cycle numbering: cycle 0 is the edge where S_IDLE samples `ap_start = 1`.
- Latency to `ap_done`: 2k+3 cycles for match index k. Minimum is 3, maximum is 33.
- `ilr` becomes valid in the same cycle `ap_done` is high.
- Reset asserted mid-search: the search is abandoned and the block returns to reset values next cycle. `ilr` clears to 0 and no `ap_done` is issued.
- `ap_idle` is low from cycle 1 through the S_DONE cycle inclusive.

## Configuration
- `ADPCM_QUANTL_PIPE_EN` defined:
  - S_MUL and S_CMP overlap; product k+1 is registered while product k is compared;
  - one table entry per cycle; latency k+3 cycles, maximum 18;
  - a match discards the in-flight product.
- `ADPCM_QUANTL_PIPE_EN` undefined: the two-cycle-per-entry FSM above.
- Results (`ilr`) are identical in both builds; only the latency differs.

## Structure
- Shared package `adpcm_quantl_pkg`:
  - the `T[0:15]` table as an 11-bit constant array;
  - `NENT`, the default `SHIFT`, and the widths 15, 11 and 27;
  - the state enum.
- One sub-module, `adpcm_quantl_mul`: a combinational 15x11 unsigned to 27-bit multiplier. Its output is registered by this block.

## Test plan
- **Smallest input**: reset, then `el = 100`, `detl = 2048` (thresholds 128(k+1)). Expect `ilr = 0x00`, done at cycle 3 (pipe build: cycle 3).
- **Negative input**: `el = -300`, `detl = 2048`. Expect k = 2, `ilr = 0x12`, done at cycle 7 (pipe build: 5).
- **Saturating magnitude**: `el = -32768`, `detl = 1`. Expect saturation at k = 15, `ilr = 0x1F`, done at cycle 33 (pipe build: 18).
- **Zero inputs**: `el = 0`, `detl = 0`. Expect `0 <= 0` match at k = 0, `ilr = 0x00`.
- **Reset mid-search**: `ap_rst` for one cycle at cycle 4 of the `el = -300` case. Expect no `ap_done`, `ilr = 0`, `ap_idle = 1` on the next cycle.
- **Handshake**: hold `ap_start` high across two searches. Expect the second capture on the cycle after S_DONE, and `ap_start` ignored while busy with changing `el`/`detl` (only the captured values are used).

Source files
------------

// File: rtl/adpcm_quantl_pkg.sv
// +--------------------------------------------------------------------------+
// | adpcm_quantl_pkg                                                         |
// | Shared constants, threshold table and FSM state type for the quantiser. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package adpcm_quantl_pkg;

  localparam int NENT      = 16;
  localparam int SHIFT_DEF = 11;
  localparam int DETL_W    = 15;
  localparam int TAB_W     = 11;
  localparam int PROD_W    = 27;
  localparam int EL_W      = 16;
  localparam int IDX_W     = 4;
  localparam int THR_W     = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Linear steps of 128, with the last entry as a saturating catch-all.
  localparam logic [TAB_W-1:0] T_TAB [0:NENT-1] = '{
    11'd128,  11'd256,  11'd384,  11'd512,
    11'd640,  11'd768,  11'd896,  11'd1024,
    11'd1152, 11'd1280, 11'd1408, 11'd1536,
    11'd1664, 11'd1792, 11'd1920, 11'd2047
  };

endpackage

`default_nettype wire

// File: rtl/adpcm_quantl_search_mul.sv
// +--------------------------------------------------------------------------+
// | adpcm_quantl_mul                                                         |
// | Combinational 15x11 unsigned multiplier with a 27-bit product.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module adpcm_quantl_mul
  import adpcm_quantl_pkg::*;
(
  input  logic [DETL_W-1:0] a_i,
  input  logic [TAB_W-1:0]  b_i,
  output logic [PROD_W-1:0] p_o
);

  assign p_o = {{(PROD_W-DETL_W){1'b0}}, a_i} * {{(PROD_W-TAB_W){1'b0}}, b_i};

endmodule

`default_nettype wire

// File: rtl/adpcm_quantl_search.sv
// +--------------------------------------------------------------------------+
// | adpcm_quantl_search                                                      |
// | Sequential threshold search producing the 5-bit {sign,index} code.      |
// | Option: ADPCM_QUANTL_PIPE_EN overlaps multiply and compare (1 entry/clk)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module adpcm_quantl_search
  import adpcm_quantl_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF
)(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [EL_W-1:0]   el,
  input  logic [DETL_W-1:0] detl,
  output logic [4:0]        ilr
);

  state_t              state_q;
  logic [IDX_W-1:0]    k_q;
  logic [DETL_W-1:0]   detl_q;
  logic                sign_q;
  logic [DETL_W-1:0]   wd_q;
  logic [PROD_W-1:0]   prod_q;
  logic [4:0]          ilr_q;
  logic                done_q;
  logic                idle_q;

  logic [DETL_W-1:0]   wd_d;
  logic [IDX_W-1:0]    mul_idx_d;
  logic [PROD_W-1:0]   prod_d;
  logic [THR_W-1:0]    thr_d;
  logic                hit_d;

  // -32768 has no 15-bit magnitude, so it clamps to the largest one.
  assign wd_d = !el[EL_W-1]          ? el[DETL_W-1:0] :
                (el == 16'h8000)     ? 15'h7FFF :
                                       15'(~el + 16'd1);

`ifdef ADPCM_QUANTL_PIPE_EN
  // While comparing entry k, the multiplier already works on entry k+1.
  assign mul_idx_d = (state_q == S_CMP) ? k_q + 4'd1 : k_q;
`else
  assign mul_idx_d = k_q;
`endif

  adpcm_quantl_mul u_mul (
    .a_i (detl_q),
    .b_i (T_TAB[mul_idx_d]),
    .p_o (prod_d)
  );

  assign thr_d = THR_W'(prod_q >> SHIFT);
  assign hit_d = ({1'b0, wd_q} <= thr_d);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      detl_q  <= '0;
      sign_q  <= 1'b0;
      wd_q    <= '0;
      prod_q  <= '0;
      ilr_q   <= '0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            detl_q  <= detl;
            sign_q  <= el[EL_W-1];
            wd_q    <= wd_d;
            k_q     <= '0;
            idle_q  <= 1'b0;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          prod_q  <= prod_d;
          state_q <= S_CMP;
        end
        S_CMP: begin
          if (hit_d || (k_q == 4'd15)) begin
            ilr_q   <= {sign_q, k_q};
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + 4'd1;
`ifdef ADPCM_QUANTL_PIPE_EN
            prod_q  <= prod_d;
            state_q <= S_CMP;
`else
            state_q <= S_MUL;
`endif
          end
        end
        S_DONE: begin
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ap_done  = done_q;
  assign ap_ready = done_q;
  assign ap_idle  = idle_q;
  assign ilr      = ilr_q;

endmodule

`default_nettype wire
